// File: rtl/clk_div_prog.sv
// Runtime-programmable tick divider with periodic/one-shot modes and a wrapping tick counter.
// Optional square-wave output is built only when CLK_DIV_SQUARE_EN is defined.
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 100,
    parameter int EVT_WIDTH   = 16,
    parameter int AUTOSTART   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 oneshot,
    input  logic                 div_load,
    input  logic [WIDTH-1:0]     div_in,
    output logic                 tick,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     div_cur,
    output logic [EVT_WIDTH-1:0] tick_count,
    output logic                 square
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam state_e              RESET_STATE = (AUTOSTART != 0) ? S_RUN : S_IDLE;
    localparam logic [WIDTH-1:0]     DIV_RST     = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0]     ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EVT_WIDTH-1:0] ONE_E       = {{(EVT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       div_q, div_d;
    logic                   tick_q, tick_d;
    logic [EVT_WIDTH-1:0]   tc_q, tc_d;
    logic [WIDTH-1:0]       d_eff_s;
    logic                   term_s;

    // A zero divisor behaves as divide-by-one.
    assign d_eff_s = (div_q == {WIDTH{1'b0}}) ? ONE_W : div_q;
    assign term_s  = (state_q == S_RUN) && en && (count_q == (d_eff_s - ONE_W));

    // Next-state: load beats stop beats start beats counting; any control discards a terminal count.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        tc_d    = tc_q;
        if (div_load || stop || start) begin
            count_d = {WIDTH{1'b0}};
            if (div_load) begin
                div_d = div_in;
            end else begin
                div_d = div_q;
            end
            if (stop) begin
                state_d = S_IDLE;
            end else if (start) begin
                state_d = S_RUN;
                tc_d    = {EVT_WIDTH{1'b0}};
                mode_d  = oneshot;
            end else begin
                state_d = state_q;
            end
        end else if (term_s) begin
            count_d = {WIDTH{1'b0}};
            tick_d  = 1'b1;
            tc_d    = tc_q + ONE_E;
            if (mode_q) begin
                state_d = S_DONE;
            end else begin
                state_d = state_q;
            end
        end else if ((state_q == S_RUN) && en) begin
            count_d = count_q + ONE_W;
        end else begin
            count_d = count_q;
        end
    end

`ifdef CLK_DIV_SQUARE_EN
    logic [WIDTH-1:0] d_next_s;
    logic [WIDTH:0]   half_s;
    logic             square_d;
    logic             square_q;

    // High for the first ceil(D/2) counts of each period, evaluated on the post-edge count.
    always_comb begin
        d_next_s = (div_d == {WIDTH{1'b0}}) ? ONE_W : div_d;
        half_s   = ({1'b0, d_next_s} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        square_d = (state_d == S_RUN) && ({1'b0, count_d} < half_s);
    end

    // Square-wave register.
    always_ff @(posedge clk) begin
        if (reset) begin
            square_q <= 1'b0;
        end else begin
            square_q <= square_d;
        end
    end

    assign square = square_q;
`else
    assign square = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            mode_q  <= 1'b0;
            count_q <= {WIDTH{1'b0}};
            div_q   <= DIV_RST;
            tick_q  <= 1'b0;
            tc_q    <= {EVT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign tick       = tick_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign div_cur    = div_q;
    assign tick_count = tc_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (EVT_WIDTH=4) against an en-cycle-counting reference model.
module tb_clk_div_prog;

    logic        clk;
    logic        reset, en, start, stop, oneshot, div_load;
    logic [15:0] div_in;
    logic        tick, busy, done, square;
    logic [15:0] div_cur;
    logic [3:0]  tick_count;

    int errors = 0;
    int checks = 0;

    // Reference model: n = en-cycles since the last restart; a tick falls on every multiple of D.
    int m_state;   // 0 idle, 1 run, 2 done
    bit m_mode;
    int m_n;
    int m_div;
    int m_tc;
    bit m_tick;
    bit m_sq;

    clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(100), .EVT_WIDTH(4), .AUTOSTART(1)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .oneshot(oneshot),
        .div_load(div_load), .div_in(div_in), .tick(tick), .busy(busy), .done(done),
        .div_cur(div_cur), .tick_count(tick_count), .square(square)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input bit e, input bit st, input bit sp, input bit os,
                        input bit ld, input int din, input bit rs);
        int d, d2;
        reset = rs; en = e; start = st; stop = sp; oneshot = os; div_load = ld; div_in = 16'(din);
        @(posedge clk);
        d = (m_div == 0) ? 1 : m_div;
        m_tick = 1'b0;
        if (rs) begin
            m_state = 1; m_mode = 1'b0; m_n = 0; m_div = 100; m_tc = 0;
        end else if (ld || sp || st) begin
            if (ld) begin m_div = din; m_n = 0; end
            if (sp) begin
                m_state = 0; m_n = 0;
            end else if (st) begin
                m_state = 1; m_n = 0; m_tc = 0; m_mode = os;
            end
        end else if (m_state == 1 && e) begin
            m_n++;
            if (m_n % d == 0) begin
                m_tick = 1'b1;
                m_tc = (m_tc + 1) % 16;
                if (m_mode) m_state = 2;
            end
        end
        d2 = (m_div == 0) ? 1 : m_div;
`ifdef CLK_DIV_SQUARE_EN
        m_sq = !rs && (m_state == 1) && ((m_n % d2) < (d2 + 1) / 2);
`else
        m_sq = 1'b0;
`endif
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 1, 1, 7, 1);
        checks += 5;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reset_state busy=%b done=%b exp busy=1 done=0", busy, done); end
        if (div_cur !== 16'd100) begin errors++; $display("FAIL reset_div got=%0d exp=100", div_cur); end
        if (tick_count !== 4'd0) begin errors++; $display("FAIL reset_tc got=%0d exp=0", tick_count); end
        if (square !== 1'b0) begin errors++; $display("FAIL reset_square got=%b exp=0", square); end
    endtask

    task automatic test_periodic();
        int pos[$];
        for (int i = 1; i <= 300; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (tick === 1'b1) pos.push_back(i);
            checks++;
            if (tick !== m_tick || tick_count !== 4'(m_tc) || square !== m_sq) begin
                errors++;
                $display("FAIL periodic cyc=%0d tick=%b/%b tc=%0d/%0d sq=%b/%b", i, tick, m_tick, tick_count, m_tc, square, m_sq);
            end
        end
        checks += 2;
        if (pos.size() !== 3 || pos[0] !== 100 || pos[1] !== 200 || pos[2] !== 300) begin
            errors++; $display("FAIL periodic_pos got n=%0d first=%0d exp 100,200,300", pos.size(), (pos.size() > 0) ? pos[0] : -1);
        end
        if (tick_count !== 4'd3) begin errors++; $display("FAIL periodic_tc got=%0d exp=3", tick_count); end
    endtask

    task automatic test_en_gating();
        int pos[$];
        step(0, 0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 200; i++) begin
            step((i % 10) == 0, 0, 0, 0, 0, 0, 0);
            if (tick === 1'b1) pos.push_back(i);
            checks++;
            if (tick !== m_tick) begin errors++; $display("FAIL en_gate cyc=%0d tick=%b exp=%b", i, tick, m_tick); end
        end
        checks += 2;
        if (div_cur !== 16'd5) begin errors++; $display("FAIL en_gate_div got=%0d exp=5", div_cur); end
        if (pos.size() !== 4 || pos[0] !== 40 || pos[1] - pos[0] !== 50 || pos[3] - pos[2] !== 50) begin
            errors++; $display("FAIL en_gate_spacing got n=%0d first=%0d exp 4 ticks from 40 every 50", pos.size(), (pos.size() > 0) ? pos[0] : -1);
        end
    endtask

    task automatic test_oneshot();
        int nt = 0;
        step(0, 1, 0, 1, 1, 3, 0);
        for (int i = 1; i <= 25; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (tick === 1'b1) nt++;
            checks++;
            if (tick !== m_tick || done !== (m_state == 2)) begin
                errors++; $display("FAIL oneshot cyc=%0d tick=%b/%b done=%b", i, tick, m_tick, done);
            end
        end
        checks += 2;
        if (nt !== 1) begin errors++; $display("FAIL oneshot_count got=%0d exp=1", nt); end
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oneshot_state done=%b busy=%b exp 1/0", done, busy); end
        nt = 0;
        step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (tick === 1'b1) nt++;
        end
        checks++;
        if (nt !== 1 || done !== 1'b1) begin errors++; $display("FAIL oneshot_restart ticks=%0d done=%b exp 1/1", nt, done); end
    endtask

    task automatic test_stop();
        logic [3:0] tc_before;
        step(0, 1, 0, 0, 1, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        tc_before = tick_count;
        step(1, 0, 1, 0, 0, 0, 0);
        checks += 2;
        if (tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL stop_state tick=%b busy=%b done=%b exp 0/0/0", tick, busy, done);
        end
        if (tick_count !== tc_before) begin errors++; $display("FAIL stop_tc got=%0d exp=%0d", tick_count, tc_before); end
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (tick !== 1'b1) begin errors++; $display("FAIL div0_tick cyc=%0d got=%b exp=1", i, tick); end
        end
        checks++;
        if (div_cur !== 16'd0) begin errors++; $display("FAIL div0_cur got=%0d exp=0", div_cur); end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 1'b0;
        logic [3:0] prev;
        step(0, 1, 0, 0, 1, 2, 0);
        prev = tick_count;
        for (int i = 1; i <= 34; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (prev == 4'd15 && tick_count == 4'd0) saw_wrap = 1'b1;
            prev = tick_count;
            checks++;
            if (tick_count !== 4'(m_tc)) begin errors++; $display("FAIL wrap_tc cyc=%0d got=%0d exp=%0d", i, tick_count, m_tc); end
        end
        checks++;
        if (tick_count !== 4'd1 || !saw_wrap) begin errors++; $display("FAIL wrap_end tc=%0d wrapped=%b exp 1/1", tick_count, saw_wrap); end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        step(0, 1, 0, 0, 1, 10, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (tick !== 1'b0 || tick_count !== 4'd0 || div_cur !== 16'd100 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid tick=%b tc=%0d div=%0d busy=%b exp 0/0/100/1", tick, tick_count, div_cur, busy);
        end
        for (int i = 1; i <= 100; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (tick === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first !== 100) begin errors++; $display("FAIL rst_mid_first got=%0d exp=100", first); end
    endtask

    task automatic test_square();
        bit exp_sq;
        step(0, 1, 0, 0, 1, 5, 0);
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) step(1, 0, 0, 0, 0, 0, 0);
`ifdef CLK_DIV_SQUARE_EN
            exp_sq = ((k % 5) < 3);
`else
            exp_sq = 1'b0;
`endif
            checks++;
            if (square !== exp_sq) begin errors++; $display("FAIL square k=%0d got=%b exp=%b", k, square, exp_sq); end
        end
    endtask

    task automatic test_random();
        bit rs, ld, sp, st;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 99) < 3);
            sp = ($urandom_range(0, 99) < 3);
            st = ($urandom_range(0, 99) < 4);
            step($urandom_range(0, 9) < 7, st, sp, 1'($urandom_range(0, 1)), ld, $urandom_range(0, 6), rs);
            checks++;
            if (tick !== m_tick || busy !== (m_state == 1) || done !== (m_state == 2) ||
                div_cur !== 16'(m_div) || tick_count !== 4'(m_tc) || square !== m_sq) begin
                errors++;
                $display("FAIL random cyc=%0d tick=%b/%b busy=%b done=%b st=%0d div=%0d/%0d tc=%0d/%0d sq=%b/%b",
                         i, tick, m_tick, busy, done, m_state, div_cur, m_div, tick_count, m_tc, square, m_sq);
            end
        end
    endtask

    initial begin
        m_state = 1; m_mode = 1'b0; m_n = 0; m_div = 100; m_tc = 0; m_tick = 1'b0; m_sq = 1'b0;
        reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; div_load = 1'b0; div_in = 16'd0;
        test_reset();
        test_periodic();
        test_en_gating();
        test_oneshot();
        test_stop();
        test_wrap();
        test_reset_mid();
        test_square();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
